// File: rtl/spi_slave_rx_pkg.sv
// Shared SPI definitions: register-select encoding for the DC line, byte
// width and the rx FIFO entry layout.
package spi_slave_rx_pkg;

    localparam logic RS_CMD = 1'b0;
    localparam logic RS_DAT = 1'b1;
    localparam int   BYTE_W = 8;

    typedef struct packed {
        logic              dc;
        logic [BYTE_W-1:0] data;
    } rx_entry_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Bundle of SPI pins, rx byte stream, tx response and status flags for the
// SPI responder. The slave modport is the responder side.
interface spi_slave_rx_if;
    import spi_slave_rx_pkg::*;

    logic              spi_cs;
    logic              spi_dc;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_dc;
    logic              rx_valid;
    logic              rx_ready;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_req;
    logic              frame_end;
    logic              err_partial;
    logic              overflow;
    logic              ovf_clr;

    modport slave (
        input  spi_cs, spi_dc, spi_sck, spi_mosi, rx_ready, tx_data, ovf_clr,
        output spi_miso, spi_miso_oe, rx_data, rx_dc, rx_valid, tx_req,
               frame_end, err_partial, overflow
    );

    modport master (
        output spi_cs, spi_dc, spi_sck, spi_mosi, rx_ready, tx_data, ovf_clr,
        input  spi_miso, spi_miso_oe, rx_data, rx_dc, rx_valid, tx_req,
               frame_end, err_partial, overflow
    );

endinterface

// File: rtl/spi_slave_rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO. A write into a full FIFO is
// accepted only when a read happens in the same cycle; reads of an empty
// FIFO are ignored.
module sync_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [W-1:0]             i_wr_data,
    input  logic                     i_rd_en,
    output logic [W-1:0]             o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_rd;
    logic          w_do_wr;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_do_rd   = i_rd_en & ~o_empty;
    assign w_do_wr   = i_wr_en & (~o_full | w_do_rd);

    // storage array, no reset needed since reads are qualified by count
    always_ff @(posedge clk) begin
        if (w_do_wr)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_rd)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder with DC tagging. SPI pins are oversampled in the clk
// domain, bytes are deserialised MSB first and queued with their DC flag,
// and a response byte is shifted out on MISO.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | CS high (or not yet seen high since reset); SCK ignored
// ST_ACTIVE | frame open; rising SCK samples MOSI, falling SCK shifts MISO
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int SPI_FRE    = 200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_slave_rx_if.slave bus
);
    localparam int CNT_W = $clog2(BYTE_W);
    localparam int ENT_W = $bits(rx_entry_t);

    if (CLK_FRE * 100 < 8 * SPI_FRE) begin : g_bad_clk
        $error("spi_slave_rx: clk must be at least 8x the maximum SCK");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spi_slave_rx: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [2:0]              r_cs_sync;
    logic [2:0]              r_sck_sync;
    logic [1:0]              r_mosi_sync;
    logic [1:0]              r_dc_sync;
    logic [1:0]              r_arm_cnt;
    logic                    r_armed;
    state_t                  r_state;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [BYTE_W-2:0]       r_rx_shift;
    logic [BYTE_W-2:0]       r_tx_shift;
    logic                    r_skip_fall;
    logic                    r_miso;
    logic                    r_miso_oe;
    logic                    r_tx_req;
    logic                    r_frame_end;
    logic                    r_err_partial;
    logic                    r_push;
    rx_entry_t               r_push_entry;
    logic                    r_overflow;

    logic                    w_cs;
    logic                    w_cs_fall;
    logic                    w_cs_rise;
    logic                    w_sck_rise;
    logic                    w_sck_fall;
    logic                    w_mosi;
    logic                    w_dc;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    rx_entry_t               w_head;

    assign w_cs       = r_cs_sync[1];
    assign w_cs_fall  = ~r_cs_sync[1] &  r_cs_sync[2];
    assign w_cs_rise  =  r_cs_sync[1] & ~r_cs_sync[2];
    assign w_sck_rise =  r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall = ~r_sck_sync[1] &  r_sck_sync[2];
    assign w_mosi     = r_mosi_sync[1];
    assign w_dc       = r_dc_sync[1];
    assign w_cnt_next = w_sck_rise ? r_bit_cnt + CNT_W'(1) : r_bit_cnt;

    // two-flop synchronisers, with a third flop on CS/SCK for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync   <= 3'b111;
            r_sck_sync  <= 3'b000;
            r_mosi_sync <= 2'b00;
            r_dc_sync   <= 2'b00;
        end else begin
            r_cs_sync   <= {r_cs_sync[1:0], bus.spi_cs};
            r_sck_sync  <= {r_sck_sync[1:0], bus.spi_sck};
            r_mosi_sync <= {r_mosi_sync[0], bus.spi_mosi};
            r_dc_sync   <= {r_dc_sync[0], bus.spi_dc};
        end
    end

    // after reset, accept a CS fall only once the real pin has been seen high,
    // so a frame already in flight at reset release is ignored entirely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arm_cnt <= 2'd0;
            r_armed   <= 1'b0;
        end else if (!r_armed) begin
            if (r_arm_cnt != 2'd3)
                r_arm_cnt <= r_arm_cnt + 2'd1;
            else if (w_cs)
                r_armed <= 1'b1;
        end
    end

    // frame FSM: byte deserialiser, MISO shifter and frame status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_skip_fall   <= 1'b0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_tx_req      <= 1'b0;
            r_frame_end   <= 1'b0;
            r_err_partial <= 1'b0;
            r_push        <= 1'b0;
            r_push_entry  <= '0;
        end else begin
            r_tx_req      <= 1'b0;
            r_frame_end   <= 1'b0;
            r_err_partial <= 1'b0;
            r_push        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall && r_armed) begin
                        r_state     <= ST_ACTIVE;
                        r_bit_cnt   <= '0;
                        r_tx_shift  <= bus.tx_data[BYTE_W-2:0];
                        r_miso      <= bus.tx_data[BYTE_W-1];
                        r_miso_oe   <= 1'b1;
                        r_tx_req    <= 1'b1;
                        r_skip_fall <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_sck_rise) begin
                        r_rx_shift <= {r_rx_shift[BYTE_W-3:0], w_mosi};
                        r_bit_cnt  <= w_cnt_next;
                        if (r_bit_cnt == CNT_W'(BYTE_W - 1)) begin
                            r_push            <= 1'b1;
                            r_push_entry.dc   <= w_dc;
                            r_push_entry.data <= {r_rx_shift, w_mosi};
                            // reload the response now; the next SCK fall must
                            // not shift, otherwise the new MSB would be lost
                            r_tx_shift        <= bus.tx_data[BYTE_W-2:0];
                            r_miso            <= bus.tx_data[BYTE_W-1];
                            r_tx_req          <= 1'b1;
                            r_skip_fall       <= 1'b1;
                        end
                    end else if (w_sck_fall) begin
                        if (r_skip_fall) begin
                            r_skip_fall <= 1'b0;
                        end else begin
                            r_miso     <= r_tx_shift[BYTE_W-2];
                            r_tx_shift <= {r_tx_shift[BYTE_W-3:0], 1'b0};
                        end
                    end
                    // CS release is handled after any coincident SCK rise
                    if (w_cs_rise) begin
                        r_state       <= ST_IDLE;
                        r_frame_end   <= 1'b1;
                        r_err_partial <= (w_cnt_next != '0);
                        r_miso        <= 1'b0;
                        r_miso_oe     <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_pop = bus.rx_ready & ~w_empty;

    sync_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (r_push),
        .i_wr_data (r_push_entry),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // sticky overflow: a byte lost to a full FIFO beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_overflow <= 1'b0;
        else if (r_push && w_full && !w_pop)
            r_overflow <= 1'b1;
        else if (bus.ovf_clr)
            r_overflow <= 1'b0;
    end

    assign bus.spi_miso    = r_miso;
    assign bus.spi_miso_oe = r_miso_oe;
    assign bus.rx_valid    = (w_count != '0);
    assign bus.rx_data     = w_empty ? '0 : w_head.data;
    assign bus.rx_dc       = w_empty ? 1'b0 : w_head.dc;
    assign bus.tx_req      = r_tx_req;
    assign bus.frame_end   = r_frame_end;
    assign bus.err_partial = r_err_partial;
    assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives SPI mode-0 frames at SCK = clk/10
// and checks received entries, MISO response, status pulses and reset.
module tb_spi_slave_rx;
    import spi_slave_rx_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_slave_rx_if bus ();

    spi_slave_rx #(
        .CLK_FRE    (50),
        .SPI_FRE    (200),
        .FIFO_DEPTH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int n_frame_end = 0;
    int n_err = 0;
    int n_txreq = 0;
    logic [8:0] q[$];

    // consumer side and pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && bus.rx_valid && bus.rx_ready)
            q.push_back({bus.rx_dc, bus.rx_data});
        if (bus.frame_end)   n_frame_end++;
        if (bus.err_partial) n_err++;
        if (bus.tx_req)      n_txreq++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, output logic m);
        bus.spi_mosi = b;
        step(5);
        m = bus.spi_miso;
        bus.spi_sck = 1'b1;
        step(5);
        bus.spi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b, output logic [7:0] m);
        logic mb;
        bus.spi_dc = dc;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], mb);
            m[i] = mb;
        end
    endtask

    task automatic cs_low();
        bus.spi_cs = 1'b0;
        step(8);
    endtask

    task automatic cs_high();
        step(5);
        bus.spi_cs = 1'b1;
        step(8);
    endtask

    task automatic expect_entry(input string tag, input logic [8:0] exp);
        logic [9:0] got;
        int w;
        w = 0;
        while (q.size() == 0 && w < 200) begin
            step(1);
            w++;
        end
        if (q.size() != 0) got = {1'b0, q.pop_front()};
        else               got = 10'h3FF;
        chk(tag, 32'(got), 32'({1'b0, exp}));
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] m1;
        logic [7:0] m2;
        logic       mb;
        logic [7:0] cmd;
        int         base_fe;
        int         base_err;
        int         base_tx;

        bus.spi_cs   = 1'b1;
        bus.spi_dc   = 1'b0;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.rx_ready = 1'b0;
        bus.tx_data  = 8'h00;
        bus.ovf_clr  = 1'b0;
        rst_n        = 1'b0;

        // reset state
        step(3);
        chk("rst_rx_valid", 32'(bus.rx_valid), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        chk("rst_miso", 32'(bus.spi_miso), 0);
        chk("rst_miso_oe", 32'(bus.spi_miso_oe), 0);
        chk("rst_tx_req", 32'(bus.tx_req), 0);
        rst_n = 1'b1;
        step(6);

        // single command byte 0x2A with push-to-valid timing
        cmd = 8'h2A;
        cs_low();
        chk("oe_in_frame", 32'(bus.spi_miso_oe), 1);
        bus.spi_dc = RS_CMD;
        for (int i = 7; i >= 1; i--) send_bit(cmd[i], mb);
        bus.spi_mosi = cmd[0];
        step(5);
        bus.spi_sck = 1'b1;
        step(3);
        chk("cmd_valid_before_push", 32'(bus.rx_valid), 0);
        step(1);
        chk("cmd_valid_after_push", 32'(bus.rx_valid), 1);
        step(4);
        bus.spi_sck = 1'b0;
        cs_high();
        chk("cmd_frame_end_cnt", 32'(n_frame_end), 1);
        chk("cmd_err_partial_cnt", 32'(n_err), 0);
        chk("cmd_head_held", 32'({bus.rx_dc, bus.rx_data}), 32'h02A);
        bus.rx_ready = 1'b1;
        expect_entry("cmd_entry", 9'h02A);
        step(2);
        chk("cmd_drained", 32'(bus.rx_valid), 0);

        // mixed command/data frame
        cs_low();
        send_byte(RS_CMD, 8'h2C, m);
        send_byte(RS_DAT, 8'h12, m);
        send_byte(RS_DAT, 8'h34, m);
        send_byte(RS_DAT, 8'h56, m);
        cs_high();
        expect_entry("mix_0", 9'h02C);
        expect_entry("mix_1", 9'h112);
        expect_entry("mix_2", 9'h134);
        expect_entry("mix_3", 9'h156);
        chk("mix_err_partial_cnt", 32'(n_err), 0);
        chk("mix_frame_end_cnt", 32'(n_frame_end), 2);

        // MISO response bytes
        bus.tx_data = 8'hA5;
        base_tx = n_txreq;
        cs_low();
        chk("miso_txreq_at_cs", 32'(n_txreq - base_tx), 1);
        bus.tx_data = 8'h3C;
        send_byte(RS_DAT, 8'h00, m1);
        send_byte(RS_DAT, 8'h00, m2);
        cs_high();
        chk("miso_byte0", 32'(m1), 32'hA5);
        chk("miso_byte1", 32'(m2), 32'h3C);
        chk("miso_oe_after", 32'(bus.spi_miso_oe), 0);
        chk("miso_low_after", 32'(bus.spi_miso), 0);
        expect_entry("miso_rx0", 9'h100);
        expect_entry("miso_rx1", 9'h100);

        // overflow with a 16-deep FIFO
        bus.rx_ready = 1'b0;
        q.delete();
        cs_low();
        for (int k = 1; k <= 17; k++) send_byte(RS_DAT, 8'(k), m);
        cs_high();
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_head", 32'({bus.rx_dc, bus.rx_data}), 32'h101);
        bus.ovf_clr = 1'b1;
        step(1);
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(bus.overflow), 0);
        bus.rx_ready = 1'b1;
        for (int k = 1; k <= 16; k++) expect_entry($sformatf("ovf_drain_%0d", k), {1'b1, 8'(k)});
        step(4);
        chk("ovf_no_extra", 32'(q.size()), 0);
        chk("ovf_empty", 32'(bus.rx_valid), 0);

        // abort after 5 bits, then a clean byte
        base_err = n_err;
        base_fe  = n_frame_end;
        cs_low();
        bus.spi_dc = RS_DAT;
        for (int i = 0; i < 5; i++) send_bit(1'b1, mb);
        cs_high();
        chk("abort_err_partial", 32'(n_err - base_err), 1);
        chk("abort_frame_end", 32'(n_frame_end - base_fe), 1);
        chk("abort_no_push", 32'(q.size()), 0);
        cs_low();
        send_byte(RS_DAT, 8'h81, m);
        cs_high();
        expect_entry("abort_next_byte", 9'h181);
        chk("abort_no_more_err", 32'(n_err - base_err), 1);

        // reset mid-byte with entries queued
        bus.rx_ready = 1'b0;
        bus.tx_data  = 8'hFF;
        cs_low();
        send_byte(RS_DAT, 8'h11, m);
        send_byte(RS_DAT, 8'h22, m);
        send_byte(RS_DAT, 8'h33, m);
        for (int i = 0; i < 4; i++) send_bit(1'b0, mb);
        chk("rst_pre_valid", 32'(bus.rx_valid), 1);
        chk("rst_pre_miso", 32'(bus.spi_miso), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus.rx_valid), 0);
        chk("rst_async_overflow", 32'(bus.overflow), 0);
        chk("rst_async_miso", 32'(bus.spi_miso), 0);
        step(3);
        rst_n = 1'b1;
        step(6);
        base_fe = n_frame_end;
        for (int i = 0; i < 4; i++) send_bit(1'b1, mb);
        send_byte(RS_DAT, 8'h99, m);
        cs_high();
        chk("rst_tail_ignored", 32'(bus.rx_valid), 0);
        chk("rst_tail_no_frame_end", 32'(n_frame_end - base_fe), 0);
        bus.rx_ready = 1'b1;
        cs_low();
        send_byte(RS_CMD, 8'h55, m);
        cs_high();
        expect_entry("rst_clean_byte", 9'h055);
        step(4);
        chk("rst_clean_only", 32'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) with display-style DC line; the receiving end of the team's 4-wire SPI master.
- Oversamples CS/SCK/MOSI/DC in the clk domain and deserialises bytes tagged with DC (0 = command, 1 = data).
- Buffers received bytes in a FIFO with a valid/ready interface.
- Shifts a response byte out on MISO.
- Used as a display/peripheral model in benches and as an on-chip SPI target.

Parameters:
- CLK_FRE, 50, system clock in MHz.
- SPI_FRE, 200, maximum SCK in units of 10 kHz. Elaboration error if CLK_FRE*100 < 8*SPI_FRE, i.e. clk must be at least 8x SCK.
- FIFO_DEPTH, 16, rx FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- spi_cs  input  1  chip select, active low.
- spi_dc  input  1  data/command flag from master.
- spi_sck  input  1  serial clock.
- spi_mosi  input  1  master-out data.
- spi_miso  output  1  slave-out data.
- spi_miso_oe  output  1  MISO drive enable; high only while CS is low.
- rx_data  output  8  head-of-FIFO byte.
- rx_dc  output  1  DC flag of the head byte.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer accepts the head byte when rx_valid & rx_ready.
- tx_data  input  8  response byte, sampled at each byte start.
- tx_req  output  1  1-cycle pulse when tx_data has been sampled; the consumer updates tx_data after this pulse.
- frame_end  output  1  1-cycle pulse on CS rising edge.
- err_partial  output  1  1-cycle pulse when CS rises with 1..7 bits shifted in.
- overflow  output  1  sticky; set when a byte is dropped because the FIFO is full.
- ovf_clr  input  1  clears overflow; a same-cycle set wins over the clear.

Behaviour:
- Reset values: all outputs 0; FIFO empty; bit counter 0; state IDLE. Sync flops reset to CS=1, SCK=0, MOSI=0, DC=0.
- Input sync: 2-flop synchroniser per SPI input, plus a third flop for edge detection.
  - sck_rise = sync & ~prev; sck_fall = ~sync & prev.
  - cs_fall and cs_rise are derived the same way.
  - Pin-to-detect latency is 3 clk.
- States:
  - IDLE: cs_fall -> ACTIVE. On entry: bit_cnt=0, tx_shift=tx_data, tx_req pulse, spi_miso = tx_data[7].
  - ACTIVE, on sck_rise: rx_shift = {rx_shift[6:0], mosi}; bit_cnt++.
    - When bit_cnt goes 7->0 (8th bit): complete byte = {rx_shift[6:0], mosi}, dc = synced DC at the same sample. The byte is pushed next cycle.
    - At that same point tx_shift reloads from tx_data and tx_req pulses.
  - ACTIVE, on sck_fall: tx_shift shifts left and spi_miso = new tx_shift[7]. The fall immediately after a reload is skipped, so the new MSB is held.
  - ACTIVE, on cs_rise -> IDLE: frame_end pulse; err_partial pulse if bit_cnt≠0; partial byte discarded; spi_miso=0, oe=0.
  - cs_rise and sck_rise detected in the same cycle: process the sck_rise first, then cs_rise.
  - SCK edges while CS is high are ignored.
- Push timing: push occurs at cycle N (the cycle after the 8th rise is detected). rx_valid is high at N+1 when the FIFO was empty.
- FIFO: first-word-fall-through, storing 9 bits {dc, data}.
  - Full + push with no pop: byte dropped, overflow set.
  - Full + push + pop in the same cycle: both succeed, count unchanged.
  - Empty + push + pop: pop is ignored (rx_valid was 0).
- rx_data and rx_dc are stable while rx_valid & ~rx_ready.
- Reset mid-frame: immediate return to IDLE and FIFO flushed. If CS is still low after reset, the bench waits for the next cs_fall; bytes from the remainder of that frame are ignored.

Decomposition:
- spi_pkg holds:
  - RS_CMD=0 and RS_DAT=1, shared with the master side;
  - the BYTE_W=8 localparam;
  - the typedef rx_entry_t {logic dc; logic [7:0] data}.
- Sub-module sync_fifo: parameterised width/depth, FWFT, with full/empty/count outputs.
- The synchroniser, edge detect and shift FSM stay in spi_slave_rx.

Test Plan:
- Command byte: CS low, DC=0, MOSI 0x2A at SCK = clk/10 -> one entry {dc=0, 0x2A}; rx_valid rises 1 clk after push; frame_end pulses once.
- Mixed frame: DC=0 0x2C, then DC=1 0x12, 0x34, 0x56 with rx_ready=1 -> entries {0,2C}, {1,12}, {1,34}, {1,56} in order; err_partial never pulses.
- MISO response: tx_data=0xA5 before CS falls, 0x3C after the first tx_req -> master captures 0xA5 then 0x3C on SCK rising edges; oe=0 after CS rises.
- Overflow: rx_ready=0, send 17 bytes with FIFO_DEPTH=16 -> 16 entries held (bytes 1..16), overflow=1. Then ovf_clr -> overflow=0. Draining returns bytes 1..16.
- Abort: CS rises after 5 bits of 0xFF -> err_partial pulse, no push; the next full byte 0x81 is received correctly.
- Reset: rst_n asserted mid-byte with 3 entries queued -> rx_valid=0, overflow=0, miso=0 asynchronously; the next clean frame byte 0x55 is received.
